// File: rtl/bus_wait_ctrl.sv
// 8086 bus-cycle controller: latches the multiplexed address on ALE, decodes
// ROM/RAM/IO/unmapped regions, drives chip selects and inserts READY wait states.
module bus_wait_ctrl #(
  parameter int unsigned WS_ROM  = 2,
  parameter int unsigned WS_RAM  = 0,
  parameter int unsigned WS_IO   = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        ale,
  input  logic [15:0] adbus,
  input  logic [3:0]  asbus,
  input  logic        m_ioN,
  input  logic        bheN,
  input  logic        rdN,
  input  logic        wrN,
  output logic        ready,
  output logic [19:0] addr,
  output logic        bheN_l,
  output logic        rom_csN,
  output logic        ram_csN,
  output logic        io_csN,
  output logic        bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_STRB = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          bhe_q, bhe_d;
  logic          rom_cs_q, rom_cs_d;
  logic          ram_cs_q, ram_cs_d;
  logic          io_cs_q, io_cs_d;
  logic          unmapped_q, unmapped_d;
  logic          bus_err_q, bus_err_d;
  logic          both_q, both_d;

  logic          strobe_c;
  logic          both_c;
  logic          released_c;
  logic          active_c;
  logic          conflict_c;
  logic          wd_expire_c;
  logic          last_wait_c;
  logic [CW-1:0] cnt_load_c;
  logic          dec_rom_c, dec_ram_c, dec_io_c, dec_none_c;

  assign strobe_c    = ~rdN | ~wrN;
  assign both_c      = ~rdN & ~wrN;
  assign released_c  = rdN & wrN;
  assign active_c    = (state_q == ST_ADDR) || (state_q == ST_STRB);
  // Both strobes low is a protocol error; flag only its first cycle.
  assign conflict_c  = both_c & ~both_q & active_c & ~ale;
  assign wd_expire_c = (wd_q == CW'(TIMEOUT - 1));
  assign last_wait_c = (cnt_q == CW'(1));

  // Region decode on the address currently presented with ALE.
  always_comb begin
    dec_rom_c  = 1'b0;
    dec_ram_c  = 1'b0;
    dec_io_c   = 1'b0;
    dec_none_c = 1'b0;
    cnt_load_c = CW'(WS_RAM);
    if (m_ioN) begin
      if (asbus == 4'hF) begin
        dec_rom_c  = 1'b1;
        cnt_load_c = CW'(WS_ROM);
      end else begin
        dec_ram_c  = 1'b1;
        cnt_load_c = CW'(WS_RAM);
      end
    end else if (adbus[15:8] == 8'h00) begin
      dec_io_c   = 1'b1;
      cnt_load_c = CW'(WS_IO);
    end else begin
      dec_none_c = 1'b1;
      cnt_load_c = CW'(TIMEOUT);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ALE restarts the cycle from any state.
  always_comb begin
    state_d = state_q;
    if (ale) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (strobe_c) begin
            state_d = ST_STRB;
          end else if (wd_expire_c) begin
            state_d = ST_IDLE;
          end
        end
        ST_STRB: begin
          if (released_c) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    ready_d    = ready_q;
    addr_d     = addr_q;
    bhe_d      = bhe_q;
    rom_cs_d   = rom_cs_q;
    ram_cs_d   = ram_cs_q;
    io_cs_d    = io_cs_q;
    unmapped_d = unmapped_q;
    bus_err_d  = 1'b0;
    both_d     = both_c;

    if (ale) begin
      addr_d     = {asbus, adbus};
      bhe_d      = bheN;
      cnt_d      = cnt_load_c;
      wd_d       = '0;
      ready_d    = (cnt_load_c == '0);
      rom_cs_d   = ~dec_rom_c;
      ram_cs_d   = ~dec_ram_c;
      io_cs_d    = ~dec_io_c;
      unmapped_d = dec_none_c;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (strobe_c) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
              if (last_wait_c) begin
                ready_d = 1'b1;
                if (unmapped_q) bus_err_d = 1'b1;
              end
            end else begin
              ready_d = 1'b1;
            end
          end else if (wd_expire_c) begin
            bus_err_d = 1'b1;
            ready_d   = 1'b1;
            rom_cs_d  = 1'b1;
            ram_cs_d  = 1'b1;
            io_cs_d   = 1'b1;
          end else begin
            wd_d = wd_q + CW'(1);
          end
        end
        ST_STRB: begin
          if (released_c) begin
            ready_d  = 1'b1;
            rom_cs_d = 1'b1;
            ram_cs_d = 1'b1;
            io_cs_d  = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (last_wait_c) begin
              ready_d = 1'b1;
              if (unmapped_q) bus_err_d = 1'b1;
            end
          end else begin
            ready_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (conflict_c) bus_err_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q      <= '0;
      wd_q       <= '0;
      ready_q    <= 1'b1;
      addr_q     <= '0;
      bhe_q      <= 1'b1;
      rom_cs_q   <= 1'b1;
      ram_cs_q   <= 1'b1;
      io_cs_q    <= 1'b1;
      unmapped_q <= 1'b0;
      bus_err_q  <= 1'b0;
      both_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      bhe_q      <= bhe_d;
      rom_cs_q   <= rom_cs_d;
      ram_cs_q   <= ram_cs_d;
      io_cs_q    <= io_cs_d;
      unmapped_q <= unmapped_d;
      bus_err_q  <= bus_err_d;
      both_q     <= both_d;
    end
  end

  assign ready   = ready_q;
  assign addr    = addr_q;
  assign bheN_l  = bhe_q;
  assign rom_csN = rom_cs_q;
  assign ram_csN = ram_cs_q;
  assign io_csN  = io_cs_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed bench for bus_wait_ctrl: region cycles, wait-state counts,
// unmapped/watchdog errors, strobe conflict, ALE abandon and async reset.
module tb_bus_wait_ctrl;

  logic        clk;
  logic        resetN;
  logic        ale;
  logic [15:0] adbus;
  logic [3:0]  asbus;
  logic        m_ioN;
  logic        bheN;
  logic        rdN;
  logic        wrN;
  logic        ready;
  logic [19:0] addr;
  logic        bheN_l;
  logic        rom_csN;
  logic        ram_csN;
  logic        io_csN;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  bus_wait_ctrl #(
    .WS_ROM (2),
    .WS_RAM (0),
    .WS_IO  (3),
    .TIMEOUT(64)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .ale    (ale),
    .adbus  (adbus),
    .asbus  (asbus),
    .m_ioN  (m_ioN),
    .bheN   (bheN),
    .rdN    (rdN),
    .wrN    (wrN),
    .ready  (ready),
    .addr   (addr),
    .bheN_l (bheN_l),
    .rom_csN(rom_csN),
    .ram_csN(ram_csN),
    .io_csN (io_csN),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish before 100000ns");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an address phase at a falling edge; returns one falling edge later.
  task automatic do_ale(input logic mio, input logic [3:0] as, input logic [15:0] ad, input logic bhe);
    ale   = 1'b1;
    m_ioN = mio;
    asbus = as;
    adbus = ad;
    bheN  = bhe;
    @(negedge clk);
    ale   = 1'b0;
  endtask

  // Count falling-edge samples with ready low; stops at the first high sample.
  task automatic count_ready_low(input int max_cyc, output int n, output bit err_seen);
    n = 0;
    err_seen = 1'b0;
    while (ready === 1'b0 && n < max_cyc) begin
      if (bus_err === 1'b1) err_seen = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  int n;
  bit err_seen;
  bit cs_held;

  initial begin
    resetN = 1'b0;
    ale    = 1'b0;
    adbus  = '0;
    asbus  = '0;
    m_ioN  = 1'b1;
    bheN   = 1'b1;
    rdN    = 1'b1;
    wrN    = 1'b1;

    // Reset state
    #12;
    check("rst_ready",   32'(ready),   32'h1);
    check("rst_addr",    32'(addr),    32'h0);
    check("rst_bhe",     32'(bheN_l),  32'h1);
    check("rst_cs",      32'({rom_csN, ram_csN, io_csN}), 32'h7);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // RAM read at 01234h, zero wait states
    do_ale(1'b1, 4'h0, 16'h1234, 1'b1);
    check("ram_addr",  32'(addr),    32'h01234);
    check("ram_cs",    32'({rom_csN, ram_csN, io_csN}), 32'h5);
    check("ram_ready0", 32'(ready),  32'h1);
    rdN = 1'b0;
    n = 0;
    cs_held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready !== 1'b1) n++;
      if (ram_csN !== 1'b0) cs_held = 1'b0;
    end
    check("ram_ready_low_cnt", 32'(n), 32'd0);
    check("ram_cs_held", 32'(cs_held), 32'h1);
    rdN = 1'b1;
    @(negedge clk);
    check("ram_cs_release", 32'(ram_csN), 32'h1);
    check("ram_addr_hold",  32'(addr),    32'h01234);

    // ROM read at FFFF0h, two wait states
    @(negedge clk);
    do_ale(1'b1, 4'hF, 16'hFFF0, 1'b1);
    check("rom_addr", 32'(addr), 32'hFFFF0);
    check("rom_cs",   32'({rom_csN, ram_csN, io_csN}), 32'h3);
    rdN = 1'b0;
    count_ready_low(200, n, err_seen);
    check("rom_wait_cnt", 32'(n), 32'd2);
    check("rom_no_err",   32'(err_seen | bus_err), 32'h0);
    check("rom_cs_in_strb", 32'(rom_csN), 32'h0);
    rdN = 1'b1;
    @(negedge clk);
    check("rom_cs_release", 32'(rom_csN), 32'h1);

    // I/O write to port 0060h, three wait states, BHE low
    do_ale(1'b0, 4'h0, 16'h0060, 1'b0);
    check("io_cs",  32'({rom_csN, ram_csN, io_csN}), 32'h6);
    check("io_bhe", 32'(bheN_l), 32'h0);
    wrN = 1'b0;
    count_ready_low(200, n, err_seen);
    check("io_wait_cnt", 32'(n), 32'd3);
    check("io_no_err",   32'(err_seen | bus_err), 32'h0);
    wrN = 1'b1;
    @(negedge clk);
    check("io_cs_release", 32'(io_csN), 32'h1);

    // Unmapped I/O read at port 1234h
    do_ale(1'b0, 4'h0, 16'h1234, 1'b1);
    check("unm_cs",    32'({rom_csN, ram_csN, io_csN}), 32'h7);
    check("unm_ready", 32'(ready), 32'h0);
    rdN = 1'b0;
    count_ready_low(200, n, err_seen);
    check("unm_wait_cnt",  32'(n), 32'd64);
    check("unm_err_early", 32'(err_seen), 32'h0);
    check("unm_err_pulse", 32'(bus_err), 32'h1);
    @(negedge clk);
    check("unm_err_width", 32'(bus_err), 32'h0);
    rdN = 1'b1;
    @(negedge clk);
    check("unm_ready_end", 32'(ready), 32'h1);

    // ALE then no strobe: watchdog expires after 64 clocks
    do_ale(1'b1, 4'hF, 16'h0000, 1'b1);
    repeat (63) @(negedge clk);
    check("wd_before_err",   32'(bus_err), 32'h0);
    check("wd_before_cs",    32'(rom_csN), 32'h0);
    check("wd_before_ready", 32'(ready),   32'h0);
    @(negedge clk);
    check("wd_err",   32'(bus_err), 32'h1);
    check("wd_cs",    32'({rom_csN, ram_csN, io_csN}), 32'h7);
    check("wd_ready", 32'(ready), 32'h1);
    @(negedge clk);
    check("wd_err_width", 32'(bus_err), 32'h0);

    // Strobe while idle is ignored
    rdN = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_strobe_cs",    32'({rom_csN, ram_csN, io_csN}), 32'h7);
    check("idle_strobe_ready", 32'(ready), 32'h1);
    rdN = 1'b1;
    @(negedge clk);

    // Both strobes low together: single bus_err pulse, cycle continues
    do_ale(1'b1, 4'h1, 16'h0002, 1'b1);
    rdN = 1'b0;
    wrN = 1'b0;
    @(negedge clk);
    check("both_err", 32'(bus_err), 32'h1);
    @(negedge clk);
    check("both_err_width", 32'(bus_err), 32'h0);
    check("both_cs_kept",   32'(ram_csN), 32'h0);
    rdN = 1'b1;
    wrN = 1'b1;
    @(negedge clk);
    check("both_cs_release", 32'(ram_csN), 32'h1);

    // New ALE during a ROM wait abandons it silently
    do_ale(1'b1, 4'hF, 16'h1000, 1'b1);
    rdN = 1'b0;
    @(negedge clk);
    rdN = 1'b1;
    do_ale(1'b1, 4'h0, 16'h0200, 1'b1);
    check("abandon_cs",   32'({rom_csN, ram_csN, io_csN}), 32'h5);
    check("abandon_err",  32'(bus_err), 32'h0);
    check("abandon_ready", 32'(ready), 32'h1);
    check("abandon_addr", 32'(addr), 32'h00200);
    rdN = 1'b0;
    @(negedge clk);
    rdN = 1'b1;
    @(negedge clk);
    check("abandon_release", 32'(ram_csN), 32'h1);

    // Asynchronous reset during a ROM wait state
    do_ale(1'b1, 4'hF, 16'h4000, 1'b1);
    rdN = 1'b0;
    @(negedge clk);
    check("prerst_ready", 32'(ready), 32'h0);
    resetN = 1'b0;
    #1;
    check("arst_ready", 32'(ready),   32'h1);
    check("arst_cs",    32'(rom_csN), 32'h1);
    check("arst_addr",  32'(addr),    32'h0);
    rdN = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // Fresh RAM cycle after reset
    do_ale(1'b1, 4'h0, 16'hABCD, 1'b1);
    check("post_addr", 32'(addr), 32'h0ABCD);
    check("post_cs",   32'({rom_csN, ram_csN, io_csN}), 32'h5);
    rdN = 1'b0;
    count_ready_low(200, n, err_seen);
    check("post_wait_cnt", 32'(n), 32'd0);
    @(negedge clk);
    check("post_ready", 32'(ready), 32'h1);
    rdN = 1'b1;
    @(negedge clk);
    check("post_release", 32'(ram_csN), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
